// File: rtl/mul4_share_seq_if.sv
// Request/response bundle between the requesting datapath blocks and the
// shared-multiplier sequencer.
//
// Signals:
//   req_valid [NREQ]        per-requester request valid
//   req_ready [NREQ]        per-requester accept (one-hot or zero)
//   req_a/req_b [NREQ*W]    operands, requester r owns [r*WIDTH +: WIDTH]
//   rsp_valid / rsp_ready   result handshake
//   rsp_id   [IDW]          requester that owns the result
//   rsp_prod [2*WIDTH]      unsigned product
//
// Modports: master = requester/consumer side, slave = sequencer side.
interface mul4_share_seq_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8
) ();
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [2*WIDTH-1:0]    rsp_prod;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_prod
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_prod
  );
endinterface

// File: rtl/mul4_share_seq.sv
// Sequencer/arbiter sharing one external combinational 4x4 unsigned
// multiplier among NREQ requesters. A WIDTH x WIDTH product is built by
// walking every (A nibble, B nibble) pair through the array, one pair per
// cycle, and shift-accumulating the 8-bit partial products.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   bus            request/response bundle (slave side)
//   mul_x, mul_y   nibbles driven to the shared array (0 outside MUL)
//   mul_o          array product mul_x*mul_y, same cycle
//   busy           high whenever the FSM is not IDLE
//
// Flow: IDLE grants round-robin starting at rr_ptr, latches operands and id;
// MUL runs C*C passes; DONE holds the result until rsp_ready, then advances
// rr_ptr past the served requester.
module mul4_share_seq #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mul4_share_seq_if.slave     bus,
  output logic [3:0]          mul_x,
  output logic [3:0]          mul_y,
  input  logic [7:0]          mul_o,
  output logic                busy
);

  localparam int C     = WIDTH / 4;
  localparam int P     = C * C;
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW    = (C > 1) ? $clog2(C) : 1;
  localparam int PW    = (P > 1) ? $clog2(P) : 1;
  localparam int PRODW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [PRODW-1:0]   acc_q, acc_d;
  logic [PW-1:0]      pass_q, pass_d;
  // Nibble indices kept as separate counters so C need not be a power of two
  // (pass = i*C + j without a divider).
  logic [CW-1:0]      i_q, i_d;
  logic [CW-1:0]      j_q, j_d;

  // Round-robin grant
  logic               gnt_found;
  logic [IDW-1:0]     gnt_idx;
  logic [IDW:0]       cand;
  logic [NREQ-1:0]    gnt_vec;
  logic [WIDTH-1:0]   a_sel, b_sel;

  // Datapath helpers
  logic [WIDTH-1:0]   a_shift, b_shift;
  logic [CW+2:0]      sh;
  logic [PRODW-1:0]   part;

  // ---------------------------------------------------------------------------
  // Grant: first valid requester at or after rr_ptr, modulo NREQ. One spare
  // bit in cand lets rr_ptr+off exceed NREQ before the wrap subtraction.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(off);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!gnt_found && bus.req_valid[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (gnt_idx == IDW'(r)) begin
        a_sel = bus.req_a[r*WIDTH +: WIDTH];
        b_sel = bus.req_b[r*WIDTH +: WIDTH];
      end
    end
  end

  // Ready only in IDLE; gated by rst_n so nothing is offered while reset is
  // held even though IDLE is the reset state.
  always_comb begin
    gnt_vec = '0;
    if (rst_n && state_q == S_IDLE && gnt_found) gnt_vec[gnt_idx] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Multiplier feed and partial-product alignment
  // ---------------------------------------------------------------------------
  always_comb begin
    a_shift = a_q >> {i_q, 2'b00};
    b_shift = b_q >> {j_q, 2'b00};
    // Shift amount 4*(i+j); the extra bit keeps the sum from wrapping.
    sh      = (CW+3)'({i_q, 2'b00}) + (CW+3)'({j_q, 2'b00});
    part    = PRODW'(mul_o) << sh;
    mul_x   = 4'd0;
    mul_y   = 4'd0;
    if (state_q == S_MUL) begin
      mul_x = a_shift[3:0];
      mul_y = b_shift[3:0];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    pass_d   = pass_q;
    i_d      = i_q;
    j_d      = j_q;

    unique case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          a_d     = a_sel;
          b_d     = b_sel;
          id_d    = gnt_idx;
          acc_d   = '0;
          pass_d  = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        acc_d = acc_q + part;
        if (pass_q == PW'(P-1)) begin
          state_d = S_DONE;
        end else begin
          pass_d = pass_q + 1'b1;
          if (j_q == CW'(C-1)) begin
            j_d = '0;
            i_d = i_q + 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (bus.rsp_ready) begin
          // Next search starts just past the requester just served.
          if (id_q == IDW'(NREQ-1)) rr_ptr_d = '0;
          else                      rr_ptr_d = id_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      pass_q   <= '0;
      i_q      <= '0;
      j_q      <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      pass_q   <= pass_d;
      i_q      <= i_d;
      j_q      <= j_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: result fields are forced to 0 outside DONE so the in-progress
  // accumulator is never visible.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.req_ready = gnt_vec;
    bus.rsp_valid = (state_q == S_DONE);
    bus.rsp_prod  = (state_q == S_DONE) ? acc_q : '0;
    bus.rsp_id    = (state_q == S_DONE) ? id_q  : '0;
    busy          = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_mul4_share_seq.sv
// Scoreboard bench for mul4_share_seq (NREQ=2, WIDTH=8). Directed vectors
// with hand-computed products; expected responses are queued in the order
// the arbiter must serve them; a monitor pops and compares on each response
// handshake. The bench models the shared 4x4 array combinationally.
module tb_mul4_share_seq;
  localparam int NREQ = 2;
  localparam int W    = 8;
  localparam int LAT  = 5;

  typedef struct packed {
    logic [0:0]  id;
    logic [15:0] prod;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] mul_x, mul_y;
  logic [7:0] mul_o;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  exp_t       sb[$];
  logic [7:0] qa[NREQ][$];
  logic [7:0] qb[NREQ][$];

  mul4_share_seq_if #(.NREQ(NREQ), .WIDTH(W)) bus ();

  mul4_share_seq #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .mul_x (mul_x),
    .mul_y (mul_y),
    .mul_o (mul_o),
    .busy  (busy)
  );

  assign mul_o = {4'b0, mul_x} * {4'b0, mul_y};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic push(input int r, input logic [7:0] a, input logic [7:0] b);
    qa[r].push_back(a);
    qb[r].push_back(b);
  endtask

  task automatic expect_rsp(input logic [0:0] id, input logic [15:0] prod);
    exp_t e;
    e.id = id;
    e.prod = prod;
    sb.push_back(e);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((sb.size() > 0 || qa[0].size() > 0 || qa[1].size() > 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drained"}, (n >= 2000) ? 32'd1 : 32'd0, 32'd0);
  endtask

  // Requester driver: hold each queued request valid until it is accepted.
  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    forever begin
      @(negedge clk);
      if (bus.req_ready != '0)
        chk("req_ready_onehot", $countones(bus.req_ready), 1);
      for (int r = 0; r < NREQ; r++) begin
        if (bus.req_valid[r] && bus.req_ready[r]) begin
          void'(qa[r].pop_front());
          void'(qb[r].pop_front());
          acc_cyc = cyc;
        end
      end
      @(posedge clk);
      #1;
      for (int r = 0; r < NREQ; r++) begin
        if (qa[r].size() > 0) begin
          bus.req_valid[r]       = 1'b1;
          bus.req_a[r*W +: W]    = qa[r][0];
          bus.req_b[r*W +: W]    = qb[r][0];
        end else begin
          bus.req_valid[r] = 1'b0;
        end
      end
    end
  end

  // Monitor: latency on rsp_valid rise, scoreboard compare on handshake,
  // and array inputs must be idle outside MUL.
  initial begin
    logic prev_vld;
    exp_t e;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid && !prev_vld)
        chk("latency", cyc - acc_cyc, LAT);
      prev_vld = bus.rsp_valid;
      if (!busy || bus.rsp_valid)
        chk("mul_idle", {mul_x, mul_y}, 8'h00);
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", {bus.rsp_id, bus.rsp_prod}, 32'hDEAD);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", bus.rsp_id, e.id);
          chk("rsp_prod", bus.rsp_prod, e.prod);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [15:0] hold_prod;
    logic [0:0]  hold_id;
    int n;
    bus.rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_prod", bus.rsp_prod, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_mul", {mul_x, mul_y}, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_ready", bus.req_ready, 0);

    // 1: max operands
    push(0, 8'hFF, 8'hFF); expect_rsp(0, 16'hFE01);
    drain("t1");

    // 2: zero and identity
    push(0, 8'h00, 8'hA7); expect_rsp(0, 16'h0000);
    push(0, 8'h01, 8'hA7); expect_rsp(0, 16'h00A7);
    drain("t2");

    // 3: simultaneous requests from reset state
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    push(0, 8'h03, 8'h05); push(1, 8'h12, 8'h34);
    expect_rsp(0, 16'h000F); expect_rsp(1, 16'h03A8);
    drain("t3");

    // 4: continuous contention alternates 0,1,0,1,0,1
    push(0, 8'h11, 8'h22); push(0, 8'hAB, 8'hCD); push(0, 8'h80, 8'h02);
    push(1, 8'h0F, 8'hF0); push(1, 8'h7F, 8'h7F); push(1, 8'hFF, 8'h01);
    expect_rsp(0, 16'h0242); expect_rsp(1, 16'h0E10);
    expect_rsp(0, 16'h88EF); expect_rsp(1, 16'h3F01);
    expect_rsp(0, 16'h0100); expect_rsp(1, 16'h00FF);
    drain("t4");

    // 5: backpressure in DONE with another request pending
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    push(0, 8'h5A, 8'h3C); push(1, 8'h02, 8'h03);
    expect_rsp(0, 16'h1518); expect_rsp(1, 16'h0006);
    n = 0;
    while (!bus.rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk("t5_rsp_seen", bus.rsp_valid, 1);
    hold_prod = bus.rsp_prod;
    hold_id   = bus.rsp_id;
    chk("t5_hold_prod0", hold_prod, 16'h1518);
    repeat (2) begin
      @(negedge clk);
      chk("t5_hold_valid", bus.rsp_valid, 1);
      chk("t5_hold_prod", bus.rsp_prod, hold_prod);
      chk("t5_hold_id", bus.rsp_id, hold_id);
      chk("t5_no_ready", bus.req_ready, 0);
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    drain("t5");

    // 6: reset during pass 2 discards the in-flight product
    push(0, 8'h9C, 8'h3D); expect_rsp(0, 16'h252C);
    n = 0;
    do begin @(negedge clk); n++; end while (!busy && n < 100);
    chk("t6_busy", busy, 1);
    @(negedge clk);
    @(negedge clk);
    chk("t6_pass2_mul", {mul_x, mul_y}, 8'h9D);
    #1 rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    chk("t6_rst_outs", {bus.req_ready, bus.rsp_valid, bus.rsp_id, mul_x, mul_y, busy}, 0);
    chk("t6_rst_prod", bus.rsp_prod, 0);
    repeat (3) @(negedge clk);
    chk("t6_no_rsp", bus.rsp_valid, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_no_rsp_after", bus.rsp_valid, 0);
    push(0, 8'h9C, 8'h3D); expect_rsp(0, 16'h252C);
    drain("t6");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
